// File: rtl/req_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : req_enc_pkg
// Purpose  : Shared constants, FSM state type and popcount helper for the
//            16-to-4 sequential request encoder.
// Revision : 1.0  initial release
// ============================================================================
package req_enc_pkg;

    localparam int WIDTH = 16;
    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Number of set bits in a request vector (0..WIDTH).
    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsb_index_16.sv
`default_nettype none
// ============================================================================
// Module   : lsb_index_16
// Purpose  : Combinational lowest-set-bit finder. idx is 0 when vec is 0.
// Revision : 1.0  initial release
// ============================================================================
module lsb_index_16
    import req_enc_pkg::*;
(
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/req_encoder_16to4.sv
`default_nettype none
// ============================================================================
// Module   : req_encoder_16to4
// Purpose  : Accepts a 16-bit request vector over valid/ready and emits the
//            index of each set bit, lowest first, one per output handshake.
// Revision : 1.0  initial release
// ============================================================================
module req_encoder_16to4
    import req_enc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             busy,
    output logic             empty
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] w_pending_nxt;
    logic             r_empty;
    logic             w_empty_nxt;

    logic [IDX_W-1:0] w_idx;
    logic             w_found;
    logic [CNT_W-1:0] w_cnt;
    logic             w_emit;
    logic             w_last;
    logic             w_accept;
    logic             w_vec_zero;

    lsb_index_16 u_lsb (
        .vec   (r_pending),
        .idx   (w_idx),
        .found (w_found)
    );

    assign w_cnt      = popcount(r_pending);
    assign w_emit     = (r_state == EMIT);
    assign w_last     = w_emit && w_found && (w_cnt == CNT_W'(1));
    assign w_vec_zero = (in_vec == '0);

    // A new vector may enter in IDLE, or in the same cycle the final index leaves.
    assign in_ready = enable && (!w_emit || (w_last && out_ready));
    assign w_accept = in_valid && in_ready;

    assign out_valid   = w_emit;
    assign out_idx     = w_emit ? w_idx : '0;
    assign out_last    = w_last;
    assign pending_cnt = w_cnt;
    assign busy        = w_emit;
    assign empty       = r_empty;

    // State, pending vector and empty pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_empty   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_empty   <= w_empty_nxt;
        end
    end

    // Next-state: retire the emitted bit, then load a newly accepted vector.
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_empty_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_vec_zero) begin
                        w_empty_nxt = 1'b1;
                    end else begin
                        w_pending_nxt = in_vec;
                        w_state_nxt   = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    w_pending_nxt = r_pending & ~(c_ONE << w_idx);
                    if (w_last) begin
                        w_state_nxt = IDLE;
                        if (w_accept) begin
                            if (w_vec_zero) begin
                                w_empty_nxt = 1'b1;
                            end else begin
                                w_pending_nxt = in_vec;
                                w_state_nxt   = EMIT;
                            end
                        end
                    end
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_pending_nxt = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_req_encoder_16to4.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_encoder_16to4
// Purpose  : Self-checking bench for req_encoder_16to4. A queue of expected
//            indices models the encoder; directed scenarios are followed by
//            randomized traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_req_encoder_16to4;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic        out_last;
    logic [4:0]  pending_cnt;
    logic        busy;
    logic        empty;

    int n_cmp;
    int n_err;
    int q[$];
    logic exp_empty;

    req_encoder_16to4 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vec      (in_vec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .pending_cnt (pending_cnt),
        .busy        (busy),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check every output against the reset values.
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_idx"},   32'(out_idx), 0);
        chk({tag, "_out_last"},  32'(out_last), 0);
        chk({tag, "_cnt"},       32'(pending_cnt), 0);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_empty"},     32'(empty), 0);
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic cycle(input logic en, input logic iv, input logic [15:0] vec, input logic ordy);
        logic exp_valid;
        logic exp_rdy;
        enable    = en;
        in_valid  = iv;
        in_vec    = vec;
        out_ready = ordy;
        #1;
        exp_valid = (q.size() > 0);
        exp_rdy   = en && (q.size() == 0 || (q.size() == 1 && ordy));
        chk("in_ready",  32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("busy",      32'(busy), 32'(exp_valid));
        chk("out_idx",   32'(out_idx), exp_valid ? 32'(q[0]) : 0);
        chk("out_last",  32'(out_last), 32'(q.size() == 1));
        chk("pending_cnt", 32'(pending_cnt), 32'(q.size()));
        chk("empty",     32'(empty), 32'(exp_empty));
        if (exp_valid && ordy) void'(q.pop_front());
        exp_empty = 1'b0;
        if (iv && exp_rdy) begin
            if (vec == 16'h0) exp_empty = 1'b1;
            else for (int i = 0; i < 16; i++) if (vec[i]) q.push_back(i);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] rv;
        n_cmp     = 0;
        n_err     = 0;
        exp_empty = 1'b0;
        rst_n     = 1'b0;
        enable    = 1'b1;
        in_valid  = 1'b0;
        in_vec    = 16'h0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", 32'(in_ready), 1);

        // Three-bit... four-bit vector 8421, full throughput
        cycle(1, 1, 16'h8421, 1);
        chk("d8421_first_idx", 32'(out_idx), 0);
        chk("d8421_first_cnt", 32'(pending_cnt), 4);
        cycle(1, 0, 16'h0, 1);
        cycle(1, 0, 16'h0, 1);
        cycle(1, 0, 16'h0, 1);
        cycle(1, 0, 16'h0, 1);
        cycle(1, 0, 16'h0, 1);

        // Zero vector: one-cycle empty pulse
        cycle(1, 1, 16'h0000, 1);
        chk("zero_empty_pulse", 32'(empty), 1);
        cycle(1, 0, 16'h0, 1);
        cycle(1, 0, 16'h0, 1);

        // Backpressure on 0006, changing in_vec is ignored
        cycle(1, 1, 16'h0006, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 16'hFFFF, 0);
        chk("bp_hold_idx", 32'(out_idx), 1);
        chk("bp_hold_cnt", 32'(pending_cnt), 2);
        cycle(1, 0, 16'h0, 1);
        cycle(1, 0, 16'h0, 1);
        cycle(1, 0, 16'h0, 1);

        // Back-to-back: 0001 final index leaves as 0100 enters
        cycle(1, 1, 16'h0001, 1);
        cycle(1, 1, 16'h0100, 1);
        chk("b2b_idx", 32'(out_idx), 8);
        cycle(1, 0, 16'h0, 1);
        cycle(1, 0, 16'h0, 1);

        // Enable low blocks acceptance; emission continues with enable low
        cycle(0, 1, 16'h00F0, 1);
        cycle(0, 1, 16'h00F0, 1);
        cycle(1, 1, 16'hC000, 1);
        cycle(0, 1, 16'h0003, 1);
        cycle(0, 1, 16'h0003, 1);
        cycle(0, 0, 16'h0, 1);

        // Reset mid-stream
        cycle(1, 1, 16'hFFFF, 1);
        cycle(1, 0, 16'h0, 1);
        cycle(1, 0, 16'h0, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        q.delete();
        exp_empty = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1, 0, 16'h0, 1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0:       rv = 16'h0;
                1:       rv = 16'h1 << $urandom_range(0, 15);
                2:       rv = 16'hFFFF;
                default: rv = 16'($urandom);
            endcase
            cycle(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), rv,
                  ($urandom_range(0, 9) < 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
